// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master / one-slave Wishbone arbiter.
// Master 0 is the debug engine, master 1 is the CPU. Ownership is held for a
// whole Wishbone cycle (cyc). Ties are resolved round-robin unless
// FIXED_PRIO makes master 0 win every tie. Grants are registered, so a new
// request is seen on the slave side one clock after it is raised. Handing
// the bus from one master to the other costs one dead cycle.
module wb_arbiter2 #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    input  logic                    m0_we_i,
    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    output logic                    m0_ack_o,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    input  logic                    m1_we_i,
    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    output logic                    m1_ack_o,
    output logic [DATA_WIDTH-1:0]   m_dat_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    output logic                    s_we_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    input  logic                    s_ack_i,
    output logic [1:0]              gnt_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_G0   = 2'b01,
        ST_G1   = 2'b10
    } state_t;

    state_t      r_state;
    logic [1:0]  r_gnt;
    logic        r_last;     // 1'b0: m0 granted last, 1'b1: m1 granted last
    state_t      w_next;
    logic        w_tie_m0;   // on a tie in IDLE, does m0 win?

    // Decide who wins a simultaneous request from IDLE
    always_comb begin
        w_tie_m0 = 1'b0;
        if (FIXED_PRIO != 0) begin
            w_tie_m0 = 1'b1;
        end else begin
            w_tie_m0 = r_last;   // m1 went last, so m0 gets it now
        end
    end

    // Next-state logic: owner keeps the bus while its cyc is high
    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_next = w_tie_m0 ? ST_G0 : ST_G1;
                end else if (m0_cyc_i) begin
                    w_next = ST_G0;
                end else if (m1_cyc_i) begin
                    w_next = ST_G1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_G0: begin
                if (m0_cyc_i) begin
                    w_next = ST_G0;
                end else if (m1_cyc_i) begin
                    w_next = ST_G1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_G1: begin
                if (m1_cyc_i) begin
                    w_next = ST_G1;
                end else if (m0_cyc_i) begin
                    w_next = ST_G0;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Arbiter FSM: state, registered grant and last-granted master
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_gnt   <= 2'b00;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            case (w_next)
                ST_G0: begin
                    r_gnt  <= 2'b01;
                    r_last <= 1'b0;
                end
                ST_G1: begin
                    r_gnt  <= 2'b10;
                    r_last <= 1'b1;
                end
                default: begin
                    r_gnt  <= 2'b00;
                    r_last <= r_last;
                end
            endcase
        end
    end

    assign gnt_o   = r_gnt;
    assign m_dat_o = s_dat_i;

    // Slave-side mux: forward the granted master, drive zeros when idle
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = {ADDR_WIDTH{1'b0}};
        s_sel_o = {SEL_WIDTH{1'b0}};
        s_dat_o = {DATA_WIDTH{1'b0}};
        case (r_gnt)
            2'b01: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i & m0_cyc_i;
                s_we_o  = m0_we_i;
                s_adr_o = m0_adr_i;
                s_sel_o = m0_sel_i;
                s_dat_o = m0_dat_i;
            end
            2'b10: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i & m1_cyc_i;
                s_we_o  = m1_we_i;
                s_adr_o = m1_adr_i;
                s_sel_o = m1_sel_i;
                s_dat_o = m1_dat_i;
            end
            default: begin
                s_cyc_o = 1'b0;
            end
        endcase
    end

    // Ack routing: only the owner with cyc still high sees the slave ack
    always_comb begin
        m0_ack_o = s_ack_i & r_gnt[0] & m0_cyc_i;
        m1_ack_o = s_ack_i & r_gnt[1] & m1_cyc_i;
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Testbench for wb_arbiter2: directed vector table, hand-written corner
// sequences and a randomized run against an ownership-level model. Two
// instances share the stimulus: round-robin and fixed priority.
module tb_wb_arbiter2;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] dat [2];
    logic [AW-1:0] adr [2];
    logic [SW-1:0] sel [2];
    logic          we  [2];
    logic          cyc [2];
    logic          stb [2];
    logic [DW-1:0] sdat_in;
    logic          sack;

    // round-robin instance outputs
    logic          a_ack0, a_ack1, a_we, a_cyc, a_stb;
    logic [DW-1:0] a_mdat, a_sdat;
    logic [AW-1:0] a_adr;
    logic [SW-1:0] a_sel;
    logic [1:0]    a_gnt;
    // fixed-priority instance outputs
    logic          b_ack0, b_ack1, b_we, b_cyc, b_stb;
    logic [DW-1:0] b_mdat, b_sdat;
    logic [AW-1:0] b_adr;
    logic [SW-1:0] b_sel;
    logic [1:0]    b_gnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIO(0)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .m0_dat_i(dat[0]), .m0_adr_i(adr[0]), .m0_sel_i(sel[0]), .m0_we_i(we[0]),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_ack_o(a_ack0),
        .m1_dat_i(dat[1]), .m1_adr_i(adr[1]), .m1_sel_i(sel[1]), .m1_we_i(we[1]),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_ack_o(a_ack1),
        .m_dat_o(a_mdat), .s_dat_o(a_sdat), .s_dat_i(sdat_in), .s_adr_o(a_adr),
        .s_sel_o(a_sel), .s_we_o(a_we), .s_cyc_o(a_cyc), .s_stb_o(a_stb),
        .s_ack_i(sack), .gnt_o(a_gnt)
    );

    wb_arbiter2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIO(1)) dut_fp (
        .clk_i(clk), .rst_i(rst_n),
        .m0_dat_i(dat[0]), .m0_adr_i(adr[0]), .m0_sel_i(sel[0]), .m0_we_i(we[0]),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_ack_o(b_ack0),
        .m1_dat_i(dat[1]), .m1_adr_i(adr[1]), .m1_sel_i(sel[1]), .m1_we_i(we[1]),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_ack_o(b_ack1),
        .m_dat_o(b_mdat), .s_dat_o(b_sdat), .s_dat_i(sdat_in), .s_adr_o(b_adr),
        .s_sel_o(b_sel), .s_we_o(b_we), .s_cyc_o(b_cyc), .s_stb_o(b_stb),
        .s_ack_i(sack), .gnt_o(b_gnt)
    );

    typedef struct {
        logic       c0, c1, s0, s1, ack;
        logic [1:0] e_gnt;
        logic       e_cyc, e_stb, e_ack0, e_ack1;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
            dat[i] = '0; adr[i] = '0; sel[i] = '0;
        end
        sack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Model: who owns the bus after one edge, from the arbitration rules
    task automatic model_step(input int fp, input logic c0, input logic c1,
                              inout int owner, inout int last);
        logic c [2];
        c[0] = c0; c[1] = c1;
        if (owner >= 0 && c[owner]) begin
            owner = owner;
        end else if (owner >= 0) begin
            owner = c[1 - owner] ? (1 - owner) : -1;
        end else if (c0 && c1) begin
            owner = (fp != 0) ? 0 : (1 - last);
        end else if (c0) begin
            owner = 0;
        end else if (c1) begin
            owner = 1;
        end else begin
            owner = -1;
        end
        if (owner >= 0) last = owner;
    endtask

    task automatic check_vs_model(input string tag, input int owner,
        input logic [1:0] g, input logic sc, input logic ss, input logic [AW-1:0] sa,
        input logic [SW-1:0] sl, input logic sw, input logic [DW-1:0] sd,
        input logic k0, input logic k1, input logic [DW-1:0] md);
        logic [1:0]    e_g;
        logic          e_c, e_s, e_w;
        logic [AW-1:0] e_a;
        logic [SW-1:0] e_l;
        logic [DW-1:0] e_d;
        e_g = 2'b00; e_c = 1'b0; e_s = 1'b0; e_w = 1'b0;
        e_a = '0; e_l = '0; e_d = '0;
        if (owner >= 0) begin
            e_g = (owner == 0) ? 2'b01 : 2'b10;
            e_c = cyc[owner];
            e_s = cyc[owner] & stb[owner];
            e_w = we[owner];
            e_a = adr[owner];
            e_l = sel[owner];
            e_d = dat[owner];
        end
        chk({tag, ".gnt"}, 32'(g), 32'(e_g));
        chk({tag, ".s_cyc"}, 32'(sc), 32'(e_c));
        chk({tag, ".s_stb"}, 32'(ss), 32'(e_s));
        chk({tag, ".s_adr"}, 32'(sa), 32'(e_a));
        chk({tag, ".s_sel"}, 32'(sl), 32'(e_l));
        chk({tag, ".s_we"}, 32'(sw), 32'(e_w));
        chk({tag, ".s_dat"}, 32'(sd), 32'(e_d));
        chk({tag, ".ack0"}, 32'(k0), 32'(sack && owner == 0 && cyc[0]));
        chk({tag, ".ack1"}, 32'(k1), 32'(sack && owner == 1 && cyc[1]));
        chk({tag, ".m_dat"}, 32'(md), 32'(sdat_in));
    endtask

    vec_t vt [13];
    int   own_a, last_a, own_b, last_b;
    logic [1:0] rr_exp [3];

    initial begin
        idle_inputs();
        sdat_in = 16'hA5A5;

        // ---------------- reset state ----------------
        #3;
        chk("rst.gnt", 32'(a_gnt), 32'h0);
        chk("rst.s_cyc", 32'(a_cyc), 32'h0);
        chk("rst.s_stb", 32'(a_stb), 32'h0);
        do_reset();

        // ---------------- vector table (round-robin instance) ----------------
        //          c0    c1    s0    s1    ack   gnt    cyc   stb   ack0  ack1
        vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        adr[1] = 32'h0000_1000;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            cyc[0] = vt[i].c0; cyc[1] = vt[i].c1;
            stb[0] = vt[i].s0; stb[1] = vt[i].s1;
            sack   = vt[i].ack;
            #1;
            chk($sformatf("vec%0d.gnt", i), 32'(a_gnt), 32'(vt[i].e_gnt));
            chk($sformatf("vec%0d.s_cyc", i), 32'(a_cyc), 32'(vt[i].e_cyc));
            chk($sformatf("vec%0d.s_stb", i), 32'(a_stb), 32'(vt[i].e_stb));
            chk($sformatf("vec%0d.ack0", i), 32'(a_ack0), 32'(vt[i].e_ack0));
            chk($sformatf("vec%0d.ack1", i), 32'(a_ack1), 32'(vt[i].e_ack1));
            chk($sformatf("vec%0d.m_dat", i), 32'(a_mdat), 32'h0000_A5A5);
            if (vt[i].e_gnt == 2'b10)
                chk($sformatf("vec%0d.s_adr", i), a_adr, 32'h0000_1000);
        end

        // ---------------- repeated tie: round-robin alternates, fixed m0 ----------------
        do_reset();
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cyc[0] = 1'b1; cyc[1] = 1'b1;
            @(negedge clk); #1;
            chk($sformatf("tie%0d.rr_gnt", k), 32'(a_gnt), 32'(rr_exp[k]));
            chk($sformatf("tie%0d.fp_gnt", k), 32'(b_gnt), 32'h1);
            cyc[0] = 1'b0; cyc[1] = 1'b0;
            @(negedge clk); #1;
            chk($sformatf("tie%0d.idle", k), 32'(a_gnt), 32'h0);
        end

        // ---------------- 4-beat burst from m1 while m0 waits ----------------
        do_reset();
        @(negedge clk);
        cyc[1] = 1'b1;
        @(negedge clk);
        cyc[0] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            stb[1] = 1'b1; sack = 1'b1;
            #1;
            chk($sformatf("burst%0d.gnt", b), 32'(a_gnt), 32'h2);
            chk($sformatf("burst%0d.ack1", b), 32'(a_ack1), 32'h1);
            chk($sformatf("burst%0d.ack0", b), 32'(a_ack0), 32'h0);
            @(negedge clk);
        end
        cyc[1] = 1'b0; stb[1] = 1'b0; sack = 1'b0;
        #1;
        chk("burst.dead_cyc", 32'(a_cyc), 32'h0);
        chk("burst.dead_gnt", 32'(a_gnt), 32'h2);
        @(negedge clk); #1;
        chk("burst.handover_gnt", 32'(a_gnt), 32'h1);
        chk("burst.handover_cyc", 32'(a_cyc), 32'h1);

        // ---------------- asynchronous reset mid-transfer ----------------
        stb[0] = 1'b1;
        @(negedge clk); #1;
        chk("arst.pre_stb", 32'(a_stb), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.s_cyc", 32'(a_cyc), 32'h0);
        chk("arst.s_stb", 32'(a_stb), 32'h0);
        chk("arst.gnt", 32'(a_gnt), 32'h0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        cyc[1] = 1'b1;
        @(negedge clk); #1;
        chk("arst.after_gnt", 32'(a_gnt), 32'h2);
        chk("arst.after_cyc", 32'(a_cyc), 32'h1);

        // ---------------- randomized run against the ownership model ----------------
        do_reset();
        own_a = -1; last_a = 1;
        own_b = -1; last_b = 1;
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(3) == 0) cyc[i] = ~cyc[i];
                stb[i] = 1'($urandom);
                we[i]  = 1'($urandom);
                dat[i] = DW'($urandom);
                adr[i] = $urandom;
                sel[i] = SW'($urandom);
            end
            sack    = 1'($urandom);
            sdat_in = DW'($urandom);
            #1;
            check_vs_model("rr", own_a, a_gnt, a_cyc, a_stb, a_adr, a_sel, a_we, a_sdat,
                           a_ack0, a_ack1, a_mdat);
            check_vs_model("fp", own_b, b_gnt, b_cyc, b_stb, b_adr, b_sel, b_we, b_sdat,
                           b_ack0, b_ack1, b_mdat);
            @(posedge clk);
            model_step(0, cyc[0], cyc[1], own_a, last_a);
            model_step(1, cyc[0], cyc[1], own_b, last_b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone arbiter for the Marin SoC.
- Shares the single wb_intercon master port between the moxielite_wb core and the gdbte_uart debug engine, whose bus master port is currently unconnected.
- Grants are round-robin by default, with an optional fixed priority for the debug master.
- Ownership is held for the whole Wishbone cycle (cyc), so one master's transfer is never interleaved with the other's.

Parameters:
- DATA_WIDTH, 16: data bus width.
- ADDR_WIDTH, 32: address bus width.
- FIXED_PRIO, 0: 0 = round-robin on tie; 1 = m0 always wins a tie.

Ports:
clk_i  in  1  system clock (clk_cpu)
rst_i  in  1  reset, asynchronous, active-low
m0_dat_i  in  DATA_WIDTH  master 0 (gdb) write data
m0_adr_i  in  ADDR_WIDTH  master 0 address
m0_sel_i  in  DATA_WIDTH/8  master 0 byte select
m0_we_i  in  1  master 0 write enable
m0_cyc_i  in  1  master 0 cycle (bus request)
m0_stb_i  in  1  master 0 strobe
m0_ack_o  out  1  master 0 acknowledge
m1_dat_i  in  DATA_WIDTH  master 1 (cpu) write data
m1_adr_i  in  ADDR_WIDTH  master 1 address
m1_sel_i  in  DATA_WIDTH/8  master 1 byte select
m1_we_i  in  1  master 1 write enable
m1_cyc_i  in  1  master 1 cycle (bus request)
m1_stb_i  in  1  master 1 strobe
m1_ack_o  out  1  master 1 acknowledge
m_dat_o  out  DATA_WIDTH  read data, broadcast to both masters
s_dat_o  out  DATA_WIDTH  write data to intercon
s_dat_i  in  DATA_WIDTH  read data from intercon
s_adr_o  out  ADDR_WIDTH  address to intercon
s_sel_o  out  DATA_WIDTH/8  byte select to intercon
s_we_o  out  1  write enable to intercon
s_cyc_o  out  1  cycle to intercon
s_stb_o  out  1  strobe to intercon
s_ack_i  in  1  acknowledge from intercon
gnt_o  out  2  one-hot current grant, bit0 = m0, bit1 = m1; 00 = idle

Behaviour:
- Reset (rst_i low, async): state IDLE, gnt_o = 00, last-grant register = m1. All s_* outputs and both ack outputs are 0.
- States are IDLE, G0 and G1, registered on the rising edge of clk_i. gnt_o decodes the state: 00, 01, 10.
- IDLE transitions:
  - only m0_cyc_i -> G0.
  - only m1_cyc_i -> G1.
  - both -> the master not granted last (FIXED_PRIO=0), or G0 (FIXED_PRIO=1).
  - none -> stay IDLE.
- G0 transitions:
  - m0_cyc_i high -> stay G0.
  - m0_cyc_i low and m1_cyc_i high -> G1.
  - otherwise -> IDLE.
- G1 is symmetric to G0.
- The last-grant register updates on every entry to G0 or G1.
- Grant latency: cyc asserted at edge N (bus idle) -> gnt_o and s_cyc_o asserted after edge N+1. No combinational grant.
- Handover costs exactly one dead cycle: when the owner drops cyc, s_cyc_o falls in that cycle and the new owner is driven one edge later.
- Slave outputs are combinational muxes of the granted master's signals:
  - s_cyc_o = granted m*_cyc_i; s_stb_o = granted m*_stb_i & granted m*_cyc_i.
  - s_adr_o, s_sel_o, s_we_o, s_dat_o = granted master's inputs.
  - All slave outputs are 0 in IDLE.
- m_dat_o = s_dat_i unconditionally.
- mX_ack_o = s_ack_i & gnt_o[X] & mX_cyc_i. The non-owner never sees ack. A stray s_ack_i in IDLE is dropped.
- The owner may issue back-to-back stb (block transfer) under one cyc; the grant never changes while owner cyc is high, even if the other master is waiting.
- Starvation bound: with FIXED_PRIO=0, a waiting master is granted on the next owner release.
- Reset asserted mid-transfer: s_cyc_o and s_stb_o drop asynchronously, state returns to IDLE, and the in-flight transfer is abandoned.

Test Plan:
1. m1 alone reads adr 0x00001000. -> s_cyc_o rises 1 cycle after m1_cyc_i, gnt_o = 10. Slave ack with s_dat_i = 0xA5A5 -> m1_ack_o = 1, m_dat_o = 0xA5A5, m0_ack_o = 0.
2. m0 and m1 raise cyc in the same cycle from reset, FIXED_PRIO=0. -> G0 first. After m0 releases: one cycle with s_cyc_o = 0, then G1. Repeat the tie -> G0 again, because last = m1.
3. Same tie with FIXED_PRIO=1, repeated 3 times. -> m0 granted all 3 times.
4. m1 holds cyc across a 4-beat stb burst while m0 requests. -> gnt_o stays 10 for all 4 acks; m0 is granted on the edge after m1_cyc_i falls.
5. Assert rst_i low while G0 with stb high. -> s_cyc_o, s_stb_o, gnt_o go to 0 without a clock edge. After release, a new m1 request is granted normally.
6. Pulse s_ack_i while IDLE, and while G0 with m0_cyc_i low. -> m0_ack_o = m1_ack_o = 0.
